// File: rtl/tcp_listen_ctrl_if.sv
// ---------------------------------------------------------------------------
// tcp_listen_ctrl_if
// Groups the two AXI-Stream channels between the listen controller and the
// TCP stack.
//   m_axis_listen_port_*        : listen request (controller -> stack), 16-bit port
//   s_axis_listen_port_status_* : listen status  (stack -> controller), bit0 = opened
// Modports:
//   master : controller side (drives the request, accepts the status)
//   slave  : stack side
// ---------------------------------------------------------------------------
interface tcp_listen_ctrl_if;
    logic        m_axis_listen_port_TVALID;
    logic        m_axis_listen_port_TREADY;
    logic [15:0] m_axis_listen_port_TDATA;
    logic        s_axis_listen_port_status_TVALID;
    logic        s_axis_listen_port_status_TREADY;
    logic [7:0]  s_axis_listen_port_status_TDATA;

    modport master (
        output m_axis_listen_port_TVALID,
        input  m_axis_listen_port_TREADY,
        output m_axis_listen_port_TDATA,
        input  s_axis_listen_port_status_TVALID,
        output s_axis_listen_port_status_TREADY,
        input  s_axis_listen_port_status_TDATA
    );

    modport slave (
        input  m_axis_listen_port_TVALID,
        output m_axis_listen_port_TREADY,
        input  m_axis_listen_port_TDATA,
        output s_axis_listen_port_status_TVALID,
        input  s_axis_listen_port_status_TREADY,
        output s_axis_listen_port_status_TDATA
    );
endinterface

// File: rtl/tcp_listen_ctrl.sv
// ---------------------------------------------------------------------------
// tcp_listen_ctrl
// Opens NUM_PORTS consecutive server ports (BASE_PORT, BASE_PORT+1, ...) on
// the TCP stack listen interface, one at a time, after a power-up delay.
// Each port gets one attempt plus up to MAX_RETRIES retries; an attempt fails
// on a status with bit0 = 0 or when no status arrives within STATUS_TIMEOUT
// cycles of the request handshake.
// Ports:
//   aclk, aresetn : clock, asynchronous active-low reset (released via 2-flop sync)
//   lp            : request / status streams (tcp_listen_ctrl_if.master)
//   ports_open    : bit i set once port BASE_PORT+i is confirmed open
//   busy          : sequence in progress
//   done          : sequence finished (sticky until reset)
//   error         : some port exhausted its retries (sticky until reset)
// ---------------------------------------------------------------------------

// Per-port "confirmed open" flag; one instance per port.
module tcp_listen_port_flag (
    input  logic clk,
    input  logic rst_n,
    input  logic set,
    output logic open
);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)   open <= 1'b0;
        else if (set) open <= 1'b1;
    end
endmodule

module tcp_listen_ctrl #(
    parameter int unsigned NUM_PORTS      = 4,
    parameter logic [15:0] BASE_PORT      = 16'h0B48,
    parameter int unsigned START_DELAY    = 32768,
    parameter int unsigned STATUS_TIMEOUT = 4096,
    parameter int unsigned RETRY_GAP      = 1024,
    parameter int unsigned MAX_RETRIES    = 3
) (
    input  logic                 aclk,
    input  logic                 aresetn,
    tcp_listen_ctrl_if.master    lp,
    output logic [NUM_PORTS-1:0] ports_open,
    output logic                 busy,
    output logic                 done,
    output logic                 error
);
    localparam int IDX_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

    localparam logic [2:0] ST_DELAY = 3'd0;
    localparam logic [2:0] ST_REQ   = 3'd1;
    localparam logic [2:0] ST_WAIT  = 3'd2;
    localparam logic [2:0] ST_GAP   = 3'd3;
    localparam logic [2:0] ST_DONE  = 3'd4;

    localparam logic [31:0] DELAY_LAST = 32'(START_DELAY - 1);
    localparam logic [31:0] TO_LAST    = 32'(STATUS_TIMEOUT - 1);
    localparam logic [31:0] GAP_LAST   = 32'(RETRY_GAP - 1);
    localparam logic [3:0]  RETRY_MAX  = 4'(MAX_RETRIES);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_PORTS - 1);

    // Reset: asserted asynchronously, released on a clock edge two cycles later.
    logic [1:0] rst_sync;
    logic       rst_n;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) rst_sync <= 2'b00;
        else          rst_sync <= {rst_sync[0], 1'b1};
    end
    assign rst_n = rst_sync[1];

    logic [2:0]       state;
    logic [31:0]      cnt;     // shared by DELAY, WAIT (timeout) and GAP
    logic [IDX_W-1:0] idx;
    logic [3:0]       retry;
    logic             err_q;

    logic req_hs;
    logic st_ok;
    logic st_fail;
    logic can_retry;
    logic is_last;

    assign req_hs    = (state == ST_REQ) && lp.m_axis_listen_port_TREADY;
    // A status beat wins over a coincident timeout; beats outside WAIT are dropped.
    assign st_ok     = (state == ST_WAIT) && lp.s_axis_listen_port_status_TVALID &&
                        lp.s_axis_listen_port_status_TDATA[0];
    assign st_fail   = (state == ST_WAIT) &&
                       (lp.s_axis_listen_port_status_TVALID ?
                            !lp.s_axis_listen_port_status_TDATA[0] : (cnt == TO_LAST));
    assign can_retry = (retry < RETRY_MAX);
    assign is_last   = (idx == IDX_LAST);

    // Only bit0 of the status carries meaning.
    logic unused_status_bits;
    assign unused_status_bits = ^lp.s_axis_listen_port_status_TDATA[7:1];

    always_ff @(posedge aclk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_DELAY;
            cnt   <= '0;
            idx   <= '0;
            retry <= '0;
            err_q <= 1'b0;
        end else begin
            case (state)
                ST_DELAY: begin
                    if (cnt == DELAY_LAST) begin
                        state <= ST_REQ;
                        cnt   <= '0;
                        idx   <= '0;
                        retry <= '0;
                    end else begin
                        cnt <= cnt + 32'd1;
                    end
                end
                ST_REQ: begin
                    if (req_hs) begin
                        state <= ST_WAIT;
                        cnt   <= '0;
                    end
                end
                ST_WAIT: begin
                    if (st_ok || (st_fail && !can_retry)) begin
                        // Port settled (open or given up): move to the next one.
                        if (st_fail) err_q <= 1'b1;
                        if (is_last) begin
                            state <= ST_DONE;
                        end else begin
                            state <= ST_REQ;
                            idx   <= idx + 1'b1;
                            retry <= '0;
                        end
                    end else if (st_fail) begin
                        state <= ST_GAP;
                        retry <= retry + 4'd1;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + 32'd1;
                    end
                end
                ST_GAP: begin
                    if (cnt == GAP_LAST) begin
                        state <= ST_REQ;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + 32'd1;
                    end
                end
                ST_DONE: ;
                default: state <= ST_DELAY;
            endcase
        end
    end

    // Per-port open flags.
    for (genvar i = 0; i < NUM_PORTS; i++) begin : g_port
        tcp_listen_port_flag u_flag (
            .clk   (aclk),
            .rst_n (rst_n),
            .set   (st_ok && (idx == IDX_W'(i))),
            .open  (ports_open[i])
        );
    end

    // TDATA is forced to zero outside REQ so it reads 0 during reset.
    assign lp.m_axis_listen_port_TVALID        = (state == ST_REQ);
    assign lp.m_axis_listen_port_TDATA         = (state == ST_REQ) ? (BASE_PORT + 16'(idx)) : 16'h0000;
    assign lp.s_axis_listen_port_status_TREADY = rst_n;

    assign busy  = rst_n && (state != ST_DONE);
    assign done  = (state == ST_DONE);
    assign error = err_q;
endmodule

// File: tb/tb_tcp_listen_ctrl.sv
// ---------------------------------------------------------------------------
// tb_tcp_listen_ctrl
// Scoreboarded bench: the stack model pushes the expected next request
// (port, cycle) whenever an attempt resolves; an independent monitor pops
// and compares each new request. A second instance covers port wrap-around.
// ---------------------------------------------------------------------------
module tb_tcp_listen_ctrl;
    localparam int          N    = 4;
    localparam logic [15:0] BASE = 16'h0B48;
    localparam int          SD   = 20;
    localparam int          TO   = 12;
    localparam int          GAP  = 6;
    localparam int          MR   = 3;

    localparam int M_OK = 0, M_BAD = 1, M_TO = 2, M_OK_T = 3;

    logic aclk = 1'b0;
    logic aresetn = 1'b0;
    logic rst2_n = 1'b0;
    always #5 aclk = ~aclk;

    int cyc = 0;
    always @(posedge aclk) cyc <= cyc + 1;

    tcp_listen_ctrl_if lif ();
    tcp_listen_ctrl_if wif ();

    logic [N-1:0] ports_open;
    logic         busy, done, error;
    logic [1:0]   w_open;
    logic         w_busy, w_done, w_error;

    tcp_listen_ctrl #(
        .NUM_PORTS(N), .BASE_PORT(BASE), .START_DELAY(SD),
        .STATUS_TIMEOUT(TO), .RETRY_GAP(GAP), .MAX_RETRIES(MR)
    ) u_dut (
        .aclk(aclk), .aresetn(aresetn), .lp(lif),
        .ports_open(ports_open), .busy(busy), .done(done), .error(error)
    );

    tcp_listen_ctrl #(
        .NUM_PORTS(2), .BASE_PORT(16'hFFFF), .START_DELAY(4),
        .STATUS_TIMEOUT(8), .RETRY_GAP(2), .MAX_RETRIES(0)
    ) u_wrap (
        .aclk(aclk), .aresetn(rst2_n), .lp(wif),
        .ports_open(w_open), .busy(w_busy), .done(w_done), .error(w_error)
    );

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [15:0] port;
        int          cycle;
    } req_t;
    req_t exp_q[$];

    // Reference model state
    int           att[N];
    logic [N-1:0] open_exp;
    logic         err_exp;
    logic         fin;
    int           cur;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", name, got, want, cyc);
        end
    endtask

    // Monitor: every new request must match the head of the scoreboard.
    logic        prev_v = 1'b0;
    logic        prev_hs = 1'b0;
    logic [15:0] held = '0;
    initial begin
        req_t e;
        forever begin
            @(negedge aclk);
            #1;
            if (lif.m_axis_listen_port_TVALID && (!prev_v || prev_hs)) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_req: got port %0h at cycle %0d with none pending",
                             lif.m_axis_listen_port_TDATA, cyc);
                end else begin
                    e = exp_q.pop_front();
                    chk("req_port", lif.m_axis_listen_port_TDATA, e.port);
                    chk("req_cycle", cyc, e.cycle);
                end
                held = lif.m_axis_listen_port_TDATA;
            end else if (lif.m_axis_listen_port_TVALID) begin
                chk("req_stable", lif.m_axis_listen_port_TDATA, held);
            end
            prev_v  = lif.m_axis_listen_port_TVALID;
            prev_hs = lif.m_axis_listen_port_TVALID && lif.m_axis_listen_port_TREADY;
        end
    end

    function automatic logic [31:0] out_vec();
        return 32'({lif.m_axis_listen_port_TVALID, lif.m_axis_listen_port_TDATA, ports_open,
                    busy, done, error, lif.s_axis_listen_port_status_TREADY});
    endfunction

    task automatic do_reset();
        int r;
        @(negedge aclk);
        #2 aresetn = 1'b0;
        #1 chk("reset_outputs", out_vec(), 32'h0);
        lif.m_axis_listen_port_TREADY        = 1'b0;
        lif.s_axis_listen_port_status_TVALID = 1'b0;
        lif.s_axis_listen_port_status_TDATA  = 8'h00;
        exp_q.delete();
        for (int i = 0; i < N; i++) att[i] = 0;
        open_exp = '0;
        err_exp  = 1'b0;
        fin      = 1'b0;
        cur      = 0;
        repeat (3) @(negedge aclk);
        aresetn = 1'b1;
        r = cyc;
        exp_q.push_back(req_t'{BASE, r + 2 + SD});
        @(negedge aclk);
        chk("sts_ready_in_sync", lif.s_axis_listen_port_status_TREADY, 1'b0);
        @(negedge aclk);
        chk("sts_ready", lif.s_axis_listen_port_status_TREADY, 1'b1);
        chk("busy_start", busy, 1'b1);
        // stray status during DELAY
        @(negedge aclk);
        lif.s_axis_listen_port_status_TVALID = 1'b1;
        lif.s_axis_listen_port_status_TDATA  = 8'hFF;
        @(negedge aclk);
        lif.s_axis_listen_port_status_TVALID = 1'b0;
        @(negedge aclk);
        chk("stray_ignored", 32'({ports_open, error, done, lif.m_axis_listen_port_TVALID}), 32'h0);
    endtask

    task automatic pick(input int rid, input int p, input int a,
                        output int bp, output int mode, output int d);
        bp = 0; mode = M_OK; d = 3;
        case (rid)
            0: begin
                if (p == 1 && a == 0) bp = 50;
                if (p == 2 && a < 2) mode = M_BAD;
            end
            1: begin
                if (p == 0) mode = M_TO;
                if (p == 1 && a == 0) begin mode = M_BAD; d = TO; end
                if (p == 3) mode = M_OK_T;
            end
            3: ;
            default: begin
                bp = $urandom_range(0, 4);
                d  = $urandom_range(1, TO);
                mode = $urandom_range(0, 3);
            end
        endcase
        if (mode == M_OK_T) d = TO;
    endtask

    task automatic run_seq(input int rid, input bit abort);
        int guard, bp, mode, d, h, f;
        bit ok, adv;
        logic [7:0] sd;
        while (!fin) begin
            guard = 0;
            while (!lif.m_axis_listen_port_TVALID && guard < 500) begin
                @(negedge aclk);
                guard++;
            end
            if (!lif.m_axis_listen_port_TVALID) begin
                checks++;
                errors++;
                $display("FAIL req_wait: no request in %0d cycles, want port %0h", guard,
                         BASE + 16'(cur));
                return;
            end
            pick(rid, cur, att[cur], bp, mode, d);
            repeat (bp) @(negedge aclk);
            lif.m_axis_listen_port_TREADY = 1'b1;
            h = cyc;
            @(negedge aclk);
            lif.m_axis_listen_port_TREADY = 1'b0;
            if (abort && cur == 1) begin
                #2 aresetn = 1'b0;
                #1 chk("async_reset_in_wait", out_vec(), 32'h0);
                return;
            end
            if (mode == M_TO) begin
                repeat (TO) @(negedge aclk);
                f  = h + TO;
                ok = 1'b0;
            end else begin
                repeat (d - 1) @(negedge aclk);
                ok = (mode != M_BAD);
                sd = {7'($urandom), ok};
                lif.s_axis_listen_port_status_TVALID = 1'b1;
                lif.s_axis_listen_port_status_TDATA  = sd;
                f = cyc;
                @(negedge aclk);
                lif.s_axis_listen_port_status_TVALID = 1'b0;
            end
            // resolve the attempt from the rules alone
            att[cur]++;
            adv = 1'b1;
            if (ok) open_exp[cur] = 1'b1;
            else if (att[cur] <= MR) begin
                adv = 1'b0;
                exp_q.push_back(req_t'{BASE + 16'(cur), f + 1 + GAP});
            end else err_exp = 1'b1;
            if (adv) begin
                if (cur == N - 1) fin = 1'b1;
                else begin
                    cur++;
                    exp_q.push_back(req_t'{BASE + 16'(cur), f + 1});
                end
            end
            chk("ports_open", 32'(ports_open), 32'(open_exp));
            chk("error", error, err_exp);
            chk("done", done, fin);
            chk("busy", busy, !fin);
        end
        repeat (GAP + 5) @(negedge aclk);
        chk("no_pending_req", exp_q.size(), 0);
        chk("done_sticky", done, 1'b1);
        chk("final_open", 32'(ports_open), 32'(open_exp));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] seen[2];
        int k;
        bit pend;
        lif.m_axis_listen_port_TREADY        = 1'b0;
        lif.s_axis_listen_port_status_TVALID = 1'b0;
        lif.s_axis_listen_port_status_TDATA  = 8'h00;
        wif.m_axis_listen_port_TREADY        = 1'b1;
        wif.s_axis_listen_port_status_TVALID = 1'b0;
        wif.s_axis_listen_port_status_TDATA  = 8'h00;

        do_reset(); run_seq(0, 1'b0);   // happy path, backpressure, retry
        chk("happy_open", 32'(ports_open), 32'hF);
        do_reset(); run_seq(1, 1'b0);   // timeout exhaustion, boundary cases
        chk("exhaust_error", error, 1'b1);
        do_reset(); run_seq(3, 1'b1);   // reset in WAIT on port 1
        do_reset(); run_seq(0, 1'b0);   // full restart afterwards
        for (int i = 0; i < 3; i++) begin
            do_reset(); run_seq(2, 1'b0);
        end

        // wrap-around of the port number
        seen[0] = '0; seen[1] = '0;
        k = 0; pend = 1'b0;
        @(negedge aclk);
        rst2_n = 1'b1;
        for (int c = 0; c < 200 && !w_done; c++) begin
            @(negedge aclk);
            wif.s_axis_listen_port_status_TVALID = 1'b0;
            if (pend) begin
                wif.s_axis_listen_port_status_TVALID = 1'b1;
                wif.s_axis_listen_port_status_TDATA  = 8'h01;
                pend = 1'b0;
            end
            if (wif.m_axis_listen_port_TVALID) begin
                if (k < 2) seen[k] = wif.m_axis_listen_port_TDATA;
                k++;
                pend = 1'b1;
            end
        end
        chk("wrap_count", k, 2);
        chk("wrap_first", seen[0], 16'hFFFF);
        chk("wrap_second", seen[1], 16'h0000);
        chk("wrap_open", 32'(w_open), 32'h3);
        chk("wrap_done", w_done, 1'b1);
        chk("wrap_error", w_error, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
